pcm_loop_recorder: RTL and testbench
====================================

// Module: pcm_loop_recorder
// PURPOSE
//  Parametrised record/playback engine for signed PCM audio between the mic sampler and headphone driver.
//  Record mode stores one sample per ready_in strobe in on-chip RAM; playback loops the stored clip.
//  Optional record-path low-pass filter (4-tap moving average) selected by filter_in.
// PARAMETERS
//  DATA_W  8   sample width, signed two's complement
//  ADDR_W  16  RAM address width; DEPTH = 2**ADDR_W samples
// PORTS
//  clk_in       in   1       system clock (100 MHz); single clock domain
//  rst_in       in   1       synchronous, active-high reset
//  record_in    in   1       1 = record, 0 = playback
//  ready_in     in   1       one-cycle strobe: new mic sample valid / next output slot
//  filter_in    in   1       1 = low-pass filter on record path (needs REC_LPF_EN)
//  mic_in       in   DATA_W  signed mic sample, valid when ready_in=1
//  data_out     out  DATA_W  signed sample to headphone, registered
//  full_out     out  1       1 = recording hit DEPTH samples; further samples dropped
//  playing_out  out  1       1 = state PLAY with length > 0
// BEHAVIOUR
//  Reset: state=IDLE, wr_ptr=0, rd_ptr=0, len=0, data_out=0, full_out=0, playing_out=0, filter history=0.
//    RAM contents not cleared; len=0 makes them unreachable. Reset mid-record or mid-play aborts immediately.
//  States: IDLE, RECORD, PLAY.
//    IDLE->RECORD when record_in=1. PLAY->RECORD when record_in=1. RECORD->PLAY when record_in=0.
//    IDLE stays IDLE while record_in=0 (data_out=0).
//  RECORD entry: wr_ptr=0, full_out=0, filter history cleared.
//  RECORD, ready_in=1, wr_ptr<DEPTH:
//    write sample s to RAM[wr_ptr]; wr_ptr++; data_out<=s next cycle (live monitor, 1-cycle latency).
//    When write lands at DEPTH-1: full_out=1.
//  RECORD, ready_in=1, full_out=1: no write; data_out still monitors s.
//  s = mic_in, or filtered value when REC_LPF_EN is defined and filter_in=1.
//  RECORD->PLAY: len=wr_ptr (DEPTH when full); rd_ptr=0.
//  PLAY, ready_in=1, len>0:
//    RAM read at rd_ptr; data_out=RAM[rd_ptr] two cycles after strobe (registered RAM + output reg).
//    rd_ptr = (rd_ptr==len-1) ? 0 : rd_ptr+1.
//  PLAY, len==0: data_out=0, playing_out=0, rd_ptr held.
//  ready_in ignored when not in RECORD/PLAY. data_out holds between strobes.
//  Same-cycle record_in change and ready_in: strobe processed under the state register value
//    before the transition. First recorded sample = first strobe after RECORD is entered.
//  len needs ADDR_W+1 bits; pointers ADDR_W bits; no arithmetic wrap except rd_ptr loop.
// CONFIGURATION
//  REC_LPF_EN defined:
//    s = (x[n]+x[n-1]+x[n-2]+x[n-3]) >>> 2; sum in DATA_W+2 bits signed, truncate toward -inf.
//    History shifts on every RECORD strobe regardless of full_out.
//  REC_LPF_EN undefined: no filter logic; filter_in ignored; s = mic_in.
// STRUCTURE
//  Package pcm_rec_pkg: state enum (IDLE, RECORD, PLAY), default DATA_W/ADDR_W constants.
//  Sub-module pcm_sample_ram: single-port, write-first, 1-cycle registered read, DATA_W x 2**ADDR_W.
//    Top holds FSM, pointers, filter and output register.
// TESTING (bench uses ADDR_W=4, DATA_W=8)
//  1 Record 5 strobes (10,20,30,40,50), drop record_in, 12 strobes
//      -> data_out 10,20,30,40,50,10,...,20; playing_out=1.
//  2 Record 20 strobes (1..20) -> full_out=1 after 16th; playback loops 1..16, samples 17..20 absent.
//  3 REC_LPF_EN, filter_in=1, record 40,40,40,40,-8
//      -> stored 10,20,30,40,28; monitor data_out equals stored value 1 cycle after strobe.
//  4 record_in 1->0 with no strobes -> PLAY, len=0; strobes give data_out=0, playing_out=0.
//  5 Assert rst_in mid-playback (rd_ptr=3)
//      -> next cycle all outputs 0, IDLE; later record of 2 samples plays only those 2.
//  6 record_in rises in same cycle as strobe carrying 99 -> 99 not stored; next strobe value lands at address 0.

Source files
------------

// File: rtl/pcm_rec_pkg.sv
// Shared types and default sizes for the PCM loop recorder.
package pcm_rec_pkg;

  // Recorder operating states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    PLAY   = 2'd2
  } recState_t;

  // Default sample width (signed two's complement) and RAM address width
  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_ADDR_W = 16;

endpackage : pcm_rec_pkg

// File: rtl/pcm_sample_ram.sv
// Single-port sample RAM, write-first, one-cycle registered read.
module pcm_sample_ram
  import pcm_rec_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Write stores the sample and also returns it on the read port (write-first)
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
      rdata_q     <= wdata_i;
    end else begin
      rdata_q     <= mem[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule : pcm_sample_ram

// File: rtl/pcm_loop_recorder.sv
// Record/playback loop engine for signed PCM samples.
// Optional record-path 4-tap moving-average filter is built only when the
// macro REC_LPF_EN is defined; otherwise filter_in is ignored.
module pcm_loop_recorder
  import pcm_rec_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              record_in,
  input  logic              ready_in,
  input  logic              filter_in,
  input  logic [DATA_W-1:0] mic_in,
  output logic [DATA_W-1:0] data_out,
  output logic              full_out,
  output logic              playing_out
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_LEN = (ADDR_W+1)'(DEPTH);

  recState_t         state_q, state_d;
  logic [ADDR_W-1:0] wrPtr_q, wrPtr_d;
  logic [ADDR_W-1:0] rdPtr_q, rdPtr_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic              full_q, full_d;
  logic [DATA_W-1:0] dataOut_q, dataOut_d;
  logic              readPend_q, readPend_d;

  logic              ramWe;
  logic [ADDR_W-1:0] ramAddr;
  logic [DATA_W-1:0] ramRdata;
  logic [DATA_W-1:0] sample;
  logic              enterRecord;

  assign enterRecord = (state_q != RECORD) && (state_d == RECORD);

`ifdef REC_LPF_EN
  logic [DATA_W-1:0]        hist1_q, hist2_q, hist3_q;
  logic signed [DATA_W+1:0] filtSum;
  logic signed [DATA_W+1:0] filtAvg;

  assign filtSum = $signed({{2{mic_in[DATA_W-1]}},  mic_in})
                 + $signed({{2{hist1_q[DATA_W-1]}}, hist1_q})
                 + $signed({{2{hist2_q[DATA_W-1]}}, hist2_q})
                 + $signed({{2{hist3_q[DATA_W-1]}}, hist3_q});
  assign filtAvg = filtSum >>> 2;
  assign sample  = filter_in ? filtAvg[DATA_W-1:0] : mic_in;

  // Filter history shifts on every record strobe and clears on record entry
  always_ff @(posedge clk_in) begin
    if (rst_in || enterRecord) begin
      hist1_q <= '0;
      hist2_q <= '0;
      hist3_q <= '0;
    end else if (state_q == RECORD && ready_in) begin
      hist1_q <= mic_in;
      hist2_q <= hist1_q;
      hist3_q <= hist2_q;
    end
  end
`else
  logic unusedFilter;
  assign unusedFilter = filter_in;
  assign sample       = mic_in;
`endif

  pcm_sample_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk_i  (clk_in),
    .we_i   (ramWe),
    .addr_i (ramAddr),
    .wdata_i(sample),
    .rdata_o(ramRdata)
  );

  // Next-state logic: record_in alone selects between RECORD and PLAY
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (record_in)  state_d = RECORD;
      RECORD:  if (!record_in) state_d = PLAY;
      PLAY:    if (record_in)  state_d = RECORD;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: strobes act under the current state; transition side effects follow
  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    len_d      = len_q;
    full_d     = full_q;
    dataOut_d  = dataOut_q;
    readPend_d = 1'b0;
    ramWe      = 1'b0;
    ramAddr    = rdPtr_q;

    case (state_q)
      IDLE: begin
        dataOut_d = '0;
      end
      RECORD: begin
        ramAddr = wrPtr_q;
        if (ready_in) begin
          dataOut_d = sample;
          if (!full_q) begin
            ramWe   = 1'b1;
            wrPtr_d = wrPtr_q + 1'b1;
            if (wrPtr_q == {ADDR_W{1'b1}}) full_d = 1'b1;
          end
        end
        if (state_d == PLAY) begin
          len_d   = full_d ? DEPTH_LEN : {1'b0, wrPtr_d};
          rdPtr_d = '0;
        end
      end
      PLAY: begin
        if (len_q == '0) begin
          dataOut_d = '0;
        end else begin
          if (readPend_q) dataOut_d = ramRdata;
          if (ready_in) begin
            readPend_d = 1'b1;
            rdPtr_d    = ({1'b0, rdPtr_q} == len_q - 1'b1) ? '0 : rdPtr_q + 1'b1;
          end
        end
      end
      default: begin
        dataOut_d = '0;
      end
    endcase

    if (enterRecord) begin
      wrPtr_d = '0;
      full_d  = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      len_q      <= '0;
      full_q     <= 1'b0;
      dataOut_q  <= '0;
      readPend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      len_q      <= len_d;
      full_q     <= full_d;
      dataOut_q  <= dataOut_d;
      readPend_q <= readPend_d;
    end
  end

  assign data_out    = dataOut_q;
  assign full_out    = full_q;
  assign playing_out = (state_q == PLAY) && (len_q != '0);

endmodule : pcm_loop_recorder

// File: tb/tb_pcm_loop_recorder.sv
// Directed bench for pcm_loop_recorder with ADDR_W=4 (16 samples), DATA_W=8.
// Test 3 expectations depend on whether REC_LPF_EN is defined.
module tb_pcm_loop_recorder;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;

  logic              clock;
  logic              reset;
  logic              recordIn;
  logic              readyIn;
  logic              filterIn;
  logic [DATA_W-1:0] micIn;
  logic [DATA_W-1:0] dataOut;
  logic              fullOut;
  logic              playingOut;

  int total;
  int bad;

  pcm_loop_recorder #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk_in     (clock),
    .rst_in     (reset),
    .record_in  (recordIn),
    .ready_in   (readyIn),
    .filter_in  (filterIn),
    .mic_in     (micIn),
    .data_out   (dataOut),
    .full_out   (fullOut),
    .playing_out(playingOut)
  );

  // 100 MHz clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Compare one observed value against the bench's expectation
  task automatic checkOutput(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge
  task automatic applyStimulus(input logic rec, input logic rdy, input logic filt,
                               input logic [DATA_W-1:0] mic);
    recordIn = rec;
    readyIn  = rdy;
    filterIn = filt;
    micIn    = mic;
    @(posedge clock);
    #1;
  endtask

  // One strobe followed by one quiet cycle so playback output is settled
  task automatic strobe(input logic rec, input logic filt, input logic [DATA_W-1:0] mic);
    applyStimulus(rec, 1'b1, filt, mic);
    applyStimulus(rec, 1'b0, filt, 8'd0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
    reset = 1'b0;
  endtask

  function automatic int sdata();
    return int'($signed(dataOut));
  endfunction

  int exp1 [5] = '{10, 20, 30, 40, 50};
  int mic3 [5] = '{40, 40, 40, 40, -8};
  int exp3 [5];

  initial begin
    total    = 0;
    bad      = 0;
    reset    = 1'b0;
    recordIn = 1'b0;
    readyIn  = 1'b0;
    filterIn = 1'b0;
    micIn    = '0;

    // Reset state
    doReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
    checkOutput("reset_data", sdata(), 0);
    checkOutput("reset_full", int'(fullOut), 0);
    checkOutput("reset_playing", int'(playingOut), 0);

    // Test 1: record 5 samples, loop playback for 12 strobes
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 8'(exp1[i]));
      checkOutput($sformatf("t1_monitor%0d", i), sdata(), exp1[i]);
      applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
    end
    checkOutput("t1_full", int'(fullOut), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
    checkOutput("t1_playing", int'(playingOut), 1);
    for (int i = 0; i < 12; i++) begin
      strobe(1'b0, 1'b0, 8'd0);
      checkOutput($sformatf("t1_play%0d", i), sdata(), exp1[i % 5]);
    end

    // Test 2: record 20 samples, only first 16 kept
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
    checkOutput("t2_playing_rec", int'(playingOut), 0);
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 8'(i));
      if (i == 15) checkOutput("t2_full15", int'(fullOut), 0);
      if (i == 16) checkOutput("t2_full16", int'(fullOut), 1);
      if (i == 20) checkOutput("t2_monitor20", sdata(), 20);
      applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
    checkOutput("t2_playing", int'(playingOut), 1);
    for (int i = 0; i < 18; i++) begin
      strobe(1'b0, 1'b0, 8'd0);
      checkOutput($sformatf("t2_play%0d", i), sdata(), (i % 16) + 1);
    end

    // Test 3: record-path filter (or pass-through when filter not built)
`ifdef REC_LPF_EN
    exp3 = '{10, 20, 30, 40, 28};
`else
    exp3 = '{40, 40, 40, 40, -8};
`endif
    applyStimulus(1'b1, 1'b0, 1'b1, 8'd0);
    checkOutput("t3_full_cleared", int'(fullOut), 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 8'(mic3[i]));
      checkOutput($sformatf("t3_monitor%0d", i), sdata(), exp3[i]);
      applyStimulus(1'b1, 1'b0, 1'b1, 8'd0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 5; i++) begin
      strobe(1'b0, 1'b0, 8'd0);
      checkOutput($sformatf("t3_play%0d", i), sdata(), exp3[i]);
    end

    // Test 4: empty recording gives silent, non-playing PLAY
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
    checkOutput("t4_playing", int'(playingOut), 0);
    for (int i = 0; i < 3; i++) begin
      strobe(1'b0, 1'b0, 8'd0);
      checkOutput($sformatf("t4_data%0d", i), sdata(), 0);
    end
    checkOutput("t4_playing_after", int'(playingOut), 0);

    // Test 5: reset during playback, then a fresh 2-sample clip
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 5; i++) strobe(1'b1, 1'b0, 8'(11 + i));
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 3; i++) strobe(1'b0, 1'b0, 8'd0);
    checkOutput("t5_pre_reset", sdata(), 13);
    doReset();
    checkOutput("t5_rst_data", sdata(), 0);
    checkOutput("t5_rst_full", int'(fullOut), 0);
    checkOutput("t5_rst_playing", int'(playingOut), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
    strobe(1'b1, 1'b0, 8'd5);
    strobe(1'b1, 1'b0, 8'd6);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 4; i++) begin
      strobe(1'b0, 1'b0, 8'd0);
      checkOutput($sformatf("t5_play%0d", i), sdata(), (i % 2 == 0) ? 5 : 6);
    end

    // Test 6: strobe coincident with record_in rising is not stored
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd99);
    checkOutput("t6_idle_data", sdata(), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
    strobe(1'b1, 1'b0, 8'd77);
    strobe(1'b1, 1'b0, 8'd88);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 3; i++) begin
      strobe(1'b0, 1'b0, 8'd0);
      checkOutput($sformatf("t6_play%0d", i), sdata(), (i % 2 == 0) ? 77 : 88);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pcm_loop_recorder
